// File: rtl/xcorr_seq.sv
// xcorr_seq: sliding-window complex correlator. Each pass correlates every window pair
// (j<=k) into its own complex accumulator; a run integrates several passes over the stream.
module xcorr_seq #(
   parameter int WIND_SIZE    = 3,
   parameter int INTEG_LENGTH = 10,
   parameter int ACC_W        = 32
) (
   input  logic             clk_i,
   input  logic             arst_i,
   input  logic             start_i,
   output logic             busy_o,
   output logic             done_o,
   input  logic             s_valid_i,
   input  logic [15:0]      s_data_i,
   output logic             s_ready_o,
   input  logic [4:0]       rd_idx_i,
   output logic [ACC_W-1:0] rd_real_o,
   output logic [ACC_W-1:0] rd_imag_o,
   output logic [2:0]       dbg_state_o
);
   localparam int W2   = 2 * WIND_SIZE;
   localparam int NACC = W2 * (W2 + 1) / 2;
   localparam int IW   = (W2 > 1) ? $clog2(W2) : 1;
   localparam int PW   = $clog2(INTEG_LENGTH + 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_FILL  = 3'd2,
      S_PASS  = 3'd3,
      S_SHIFT = 3'd4,
      S_DRAIN = 3'd5,
      S_DONE  = 3'd6
   } state_t;

   state_t          r_state;
   logic            r_busy, r_done, r_ready;
   logic [IW-1:0]   r_cnt, r_j, r_k;
   logic [4:0]      r_idx;
   logic [PW-1:0]   r_pairs;
   logic [15:0]     r_win [W2];

   // A sample transfers on a rising edge where s_valid_i && s_ready_o; data must be held
   // while valid is high and not yet accepted. Ready is a flop, so it never depends on valid.
   logic            w_take;
   logic [IW-1:0]   w_fill_idx;
   assign w_take     = s_valid_i && r_ready;
   assign w_fill_idx = r_cnt[0] ? (IW'(WIND_SIZE) + (r_cnt >> 1)) : (r_cnt >> 1);

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         r_state <= S_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_ready <= 1'b0;
         r_cnt   <= '0;
         r_j     <= '0;
         r_k     <= '0;
         r_idx   <= '0;
         r_pairs <= '0;
         for (int i = 0; i < W2; i++) r_win[i] <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start_i) begin
                  r_state <= S_CLEAR;
                  r_busy  <= 1'b1;
               end
            end
            S_CLEAR: begin
               r_state <= S_FILL;
               r_ready <= 1'b1;
               r_cnt   <= '0;
               r_pairs <= '0;
            end
            S_FILL: begin
               if (w_take) begin
                  r_win[w_fill_idx] <= s_data_i;
                  if (r_cnt[0]) r_pairs <= r_pairs + PW'(1);
                  if (r_cnt == IW'(W2 - 1)) begin
                     r_state <= S_PASS;
                     r_ready <= 1'b0;
                     r_j     <= '0;
                     r_k     <= '0;
                     r_idx   <= '0;
                  end else begin
                     r_cnt <= r_cnt + IW'(1);
                  end
               end
            end
            S_PASS: begin
               r_idx <= r_idx + 5'd1;
               if (r_k == IW'(W2 - 1)) begin
                  if (r_j == IW'(W2 - 1)) begin
                     r_cnt <= '0;
                     if (r_pairs < PW'(INTEG_LENGTH)) begin
                        r_state <= S_SHIFT;
                        r_ready <= 1'b1;
                     end else begin
                        r_state <= S_DRAIN;
                     end
                  end else begin
                     r_j <= r_j + IW'(1);
                     r_k <= r_j + IW'(1);
                  end
               end else begin
                  r_k <= r_k + IW'(1);
               end
            end
            S_SHIFT: begin
               if (w_take) begin
                  if (!r_cnt[0]) begin
                     for (int i = 0; i < WIND_SIZE - 1; i++) r_win[i] <= r_win[i+1];
                     r_win[WIND_SIZE-1] <= s_data_i;
                     r_cnt <= IW'(1);
                  end else begin
                     for (int i = WIND_SIZE; i < W2 - 1; i++) r_win[i] <= r_win[i+1];
                     r_win[W2-1] <= s_data_i;
                     r_pairs <= r_pairs + PW'(1);
                     r_state <= S_PASS;
                     r_ready <= 1'b0;
                     r_j     <= '0;
                     r_k     <= '0;
                     r_idx   <= '0;
                  end
               end
            end
            S_DRAIN: begin
               if (r_cnt == IW'(1)) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + IW'(1);
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_ready <= 1'b0;
            end
         endcase
      end
   end

   // Operand decode: the conjugate imag part wraps in 8 bits, so -(-128) stays -128.
   logic [15:0]             w_a, w_b;
   logic [7:0]              w_nb8;
   logic signed [ACC_W-1:0] w_ra, w_ia, w_rb, w_nb, w_pre, w_pim;
   assign w_a   = r_win[r_j];
   assign w_b   = r_win[r_k];
   assign w_nb8 = 8'd0 - w_b[15:8];
   assign w_ra  = {{(ACC_W-8){w_a[7]}},  w_a[7:0]};
   assign w_ia  = {{(ACC_W-8){w_a[15]}}, w_a[15:8]};
   assign w_rb  = {{(ACC_W-8){w_b[7]}},  w_b[7:0]};
   assign w_nb  = {{(ACC_W-8){w_nb8[7]}}, w_nb8};
   assign w_pre = w_ra * w_rb - w_ia * w_nb;
   assign w_pim = w_ra * w_nb + w_rb * w_ia;

   logic             r_p_vld;
   logic [4:0]       r_p_idx;
   logic [ACC_W-1:0] r_p_re, r_p_im;
   logic [ACC_W-1:0] r_acc_re [NACC];
   logic [ACC_W-1:0] r_acc_im [NACC];

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         r_p_vld <= 1'b0;
         r_p_idx <= '0;
         r_p_re  <= '0;
         r_p_im  <= '0;
         for (int i = 0; i < NACC; i++) begin
            r_acc_re[i] <= '0;
            r_acc_im[i] <= '0;
         end
      end else begin
         r_p_vld <= (r_state == S_PASS);
         r_p_idx <= r_idx;
         r_p_re  <= w_pre;
         r_p_im  <= w_pim;
         if (r_state == S_CLEAR) begin
            for (int i = 0; i < NACC; i++) begin
               r_acc_re[i] <= '0;
               r_acc_im[i] <= '0;
            end
         end else if (r_p_vld) begin
            r_acc_re[r_p_idx] <= r_acc_re[r_p_idx] + r_p_re;
            r_acc_im[r_p_idx] <= r_acc_im[r_p_idx] + r_p_im;
         end
      end
   end

   assign rd_real_o   = (32'(rd_idx_i) < NACC) ? r_acc_re[rd_idx_i] : '0;
   assign rd_imag_o   = (32'(rd_idx_i) < NACC) ? r_acc_im[rd_idx_i] : '0;
   assign busy_o      = r_busy;
   assign done_o      = r_done;
   assign s_ready_o   = r_ready;
   assign dbg_state_o = r_state;
endmodule

// File: doc/xcorr_seq.md
XCORR_SEQ -- requirements
Module: xcorr_seq

Interface
REQ-001 SHALL have parameter WIND_SIZE, default 3, meaning complex sample pairs held in the window (window depth W2 = 2*WIND_SIZE).
REQ-002 SHALL have parameter INTEG_LENGTH, default 10, meaning sample pairs consumed per run (must be >= WIND_SIZE).
REQ-003 SHALL have parameter ACC_W, default 32, meaning accumulator width per real/imag component.
REQ-004 SHALL have the following ports:
- clk_i  in  1  clock.
- arst_i  in  1  reset, asynchronous, active-high.
- start_i  in  1  run start pulse.
- busy_o  out  1  run in progress.
- done_o  out  1  one-cycle run-complete pulse.
- s_valid_i  in  1  sample valid.
- s_data_i  in  16  sample: [7:0] real, [15:8] imag, both signed.
- s_ready_o  out  1  sample accepted when s_valid_i && s_ready_o.
- rd_idx_i  in  5  accumulator read index, 0..NACC-1 with NACC = W2*(W2+1)/2 (21 at defaults).
- rd_real_o  out  ACC_W  real accumulator at rd_idx_i, combinational.
- rd_imag_o  out  ACC_W  imag accumulator at rd_idx_i, combinational.

Function
REQ-005 SHALL implement FSM states IDLE, CLEAR, FILL, PASS, SHIFT, DRAIN, DONE.
REQ-006 SHALL leave IDLE for CLEAR only on start_i; start_i in any other state SHALL be ignored.
REQ-007 CLEAR SHALL zero all 2*NACC accumulators in one cycle, then go to FILL.
REQ-008 FILL SHALL accept exactly W2 samples in stream order. Even-numbered samples SHALL fill win[0..WIND_SIZE-1]; odd-numbered samples SHALL fill win[WIND_SIZE..W2-1], each ascending. FILL then goes to PASS.
REQ-009 SHIFT SHALL accept 2 samples. On the even sample, win[0..WIND_SIZE-2] <= win[1..WIND_SIZE-1] and win[WIND_SIZE-1] <= sample. On the odd sample, the upper half shifts the same way, with the sample into win[W2-1].
REQ-010 s_ready_o SHALL be high only in FILL and SHIFT; with s_valid_i low, the FSM SHALL hold state indefinitely.
REQ-011 PASS SHALL issue one pair (j,k) per cycle for all 0<=j<=k<W2, j ascending then k ascending: NACC cycles, no stalls.
REQ-012 Pair index SHALL be idx = rowbase(j) + (k-j), where rowbase(j) = sum over m<j of (W2-m); at defaults rowbase = 0,6,11,15,18,20.
REQ-013 Operand decode: ra/ia = real/imag of win[j]; rb/ib = real/imag of win[k]; nb = 8-bit two's-complement negate of ib, wrapping (ib = -128 gives nb = -128); all operands sign-extended to ACC_W.
REQ-014 Each pair SHALL update acc_real[idx] += ra*rb - ia*nb and acc_imag[idx] += ra*nb + rb*ia, modulo 2^ACC_W, with no saturation.
REQ-015 The MAC SHALL be a 2-stage pipeline: products registered in the issue cycle, accumulator written the next cycle. Indices within a pass are distinct, so no forwarding is required.
REQ-016 After a pass, if pairs consumed < INTEG_LENGTH, go to SHIFT; else go to DRAIN. A run SHALL make 1 + (INTEG_LENGTH - WIND_SIZE) passes (8 at defaults) and consume 2*INTEG_LENGTH samples.
REQ-017 DRAIN SHALL last 2 cycles until the final accumulator write lands, then go to DONE.
REQ-018 DONE SHALL assert done_o for one cycle, then return to IDLE.
REQ-019 busy_o SHALL be high in every state except IDLE.
REQ-020 Reads SHALL be legal at any time; during a run they return in-progress values. Accumulators SHALL hold after DONE until the next CLEAR.
REQ-021 rd_idx_i >= NACC SHALL return zero on both read outputs.

Reset
REQ-022 arst_i SHALL force IDLE immediately and zero all accumulators, window registers, pipeline registers and counters, including mid-run.
REQ-023 After reset, busy_o, done_o and s_ready_o SHALL be 0, and rd_real_o and rd_imag_o SHALL read 0.
REQ-024 A start_i arriving after reset deassertion SHALL begin a clean run with no residue from the aborted run.

Verification
REQ-025 Reset: assert arst_i mid-PASS -> same cycle busy_o=0, s_ready_o=0, all rd reads 0x00000000.
REQ-026 Uniform stream: 20 samples of 16'h0101 back-to-back after start -> done_o pulse once; all 21 entries real=0x00000010, imag=0x00000000.
REQ-027 Negate wrap: 20 samples of 16'h8000 -> all 21 entries real=0xFFFE0000, imag=0x00000000.
REQ-028 Backpressure: scenario REQ-026 with s_valid_i toggled every other cycle -> identical results; s_ready_o=0 throughout every PASS (21 cycles each).
REQ-029 Start ignored: start_i pulsed in FILL and PASS -> no CLEAR, results unchanged; exactly one done_o per run.
REQ-030 Golden vector: stream 4121,0707,910B,7132,7164,3201,D159,0AB1,C203,4101,0102,3755,0145,5161,4171,7171,6373,7252,5262,9131 -> all 21 real/imag entries match the bit-exact software model of REQ-008..REQ-016.
